// File: rtl/rv32i_pkg.sv
// Shared RV32I types used by the data memory and its load extender.
package rv32i_pkg;

    // Load/store width and signedness, encoded as the instruction's funct3
    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_t;

    // Data memory sequencer: zero-fill after reset, then normal operation
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dm_state_t;

    // True for the five funct3 encodings that name a real access size
    function automatic logic dm_ctrl_valid(input logic [2:0] c);
        return (c == DM_B) || (c == DM_H) || (c == DM_W) ||
               (c == DM_BU) || (c == DM_HU);
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Selects the addressed byte/half from a memory word and sign/zero-extends it.
module dm_load_ext
    import rv32i_pkg::*;
(
    input  logic    [31:0] word,
    input  logic    [1:0]  lane,
    input  dmctrl_t        ctrl,
    output logic    [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection; halves only use lane[1] since lane[0] is zero when aligned
    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // Extension by access type; unknown encodings read as zero
    always_comb begin
        data = 32'h0;
        case (ctrl)
            DM_B:    data = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   data = {24'h0, byte_sel};
            DM_H:    data = {{16{half_sel[15]}}, half_sel};
            DM_HU:   data = {16'h0, half_sel};
            DM_W:    data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM for the single-cycle RV32I core. Byte-lane stores,
// combinational extended loads, alignment/illegal flags, and a post-reset
// zero-fill sequencer that holds `ready` low until every word is cleared.
module data_memory
    import rv32i_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        misalign,
    output logic        illegal,
    output logic        ready
);

    logic [31:0]       mem_q [DEPTH];
    dm_state_t         state_q, state_d;
    logic [ADDR_W-1:0] init_idx_q, init_idx_d;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    dmctrl_t           ctrl;
    logic              init_we;
    logic [3:0]        user_be;
    logic [31:0]       user_wdata;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [31:0]       ext_data;
    logic              unused_addr_bits;

    // Upper address bits alias; they never reach the array
    assign word_idx         = Address[ADDR_W+1:2];
    assign lane             = Address[1:0];
    assign ctrl             = dmctrl_t'(DMCtrl);
    assign unused_addr_bits = ^Address[31:ADDR_W+2];

    // Access checks: natural alignment per size, and encodings that cannot be stored
    always_comb begin
        misalign = 1'b0;
        case (ctrl)
            DM_H, DM_HU: misalign = Address[0];
            DM_W:        misalign = |Address[1:0];
            default:     misalign = 1'b0;
        endcase
        illegal = !dm_ctrl_valid(DMCtrl) ||
                  (DMWr && ((ctrl == DM_BU) || (ctrl == DM_HU)));
    end

    // Byte enables and lane-replicated store data for the user port
    always_comb begin
        user_be    = 4'b0000;
        user_wdata = DataWr;
        case (ctrl)
            DM_B: begin
                user_be    = 4'b0001 << lane;
                user_wdata = {4{DataWr[7:0]}};
            end
            DM_H: begin
                user_be    = lane[1] ? 4'b1100 : 4'b0011;
                user_wdata = {2{DataWr[15:0]}};
            end
            DM_W: begin
                user_be    = 4'b1111;
                user_wdata = DataWr;
            end
            default: user_be = 4'b0000;
        endcase
    end

    // Sequencer state register with synchronous reset back to the start of zero-fill
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Next state: walk every word once, then stay in RUN until reset
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d    = RUN;
                init_idx_d = '0;
            end
        end
    end

    // Sequencer outputs
    always_comb begin
        ready   = (state_q == RUN);
        init_we = (state_q == INIT);
    end

    // Write port: zero-fill owns it during INIT; user stores only when legal and ready
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_be   = user_be;
        wr_data = user_wdata;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_idx  = init_idx_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end else begin
            wr_en = DMWr && ready && !rst && !misalign && !illegal;
        end
    end

    // Array write, byte-lane granular; no reset on the storage itself
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_word = mem_q[word_idx];

    dm_load_ext u_load_ext (
        .word (rd_word),
        .lane (lane),
        .ctrl (ctrl),
        .data (ext_data)
    );

    // Reads return the pre-edge contents; blocked accesses read as zero
    always_comb begin
        DataRd = (ready && !misalign && !illegal) ? ext_data : 32'h0;
    end

endmodule
